line_clear_engine: RTL and testbench

Post-lock row-clear stage that sits directly downstream of the Tetris game FSM and upstream of the grid renderer. On a `start` pulse it snapshots the 22×10 colour grid and scans it bottom to top. It removes every completely filled row, collapsing the rows above it downward, and then presents the compacted grid. It also reports the number of rows removed and maintains a cumulative saturating score.

---
 rtl/line_clear_engine_if.sv | 26 ++
 rtl/line_clear_engine.sv | 119 +++++++++++
 tb/tb_line_clear_engine.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/line_clear_engine_if.sv
// Bundles the start/grid request side and the compacted-grid result side of the row-clear stage.
// The game FSM side uses the master modport; the engine uses the slave modport.
// Parameters must match those of the engine instance that it connects to.
interface line_clear_engine_if #(
  parameter int ROWS    = 22,
  parameter int COLS    = 10,
  parameter int SCORE_W = 16
);
  logic                              start;
  logic [ROWS-1:0][COLS-1:0][2:0]    grid_in;
  logic [ROWS-1:0][COLS-1:0][2:0]    grid_out;
  logic                              busy;
  logic                              done;
  logic [4:0]                        lines_cleared;
  logic [SCORE_W-1:0]                score;

  modport master (
    output start, grid_in,
    input  grid_out, busy, done, lines_cleared, score
  );

  modport slave (
    input  start, grid_in,
    output grid_out, busy, done, lines_cleared, score
  );
endinterface

// File: rtl/line_clear_engine.sv
// Purpose: snapshot a locked grid, remove full rows bottom-up, and publish the compacted grid and a saturating score.
// Latency: done is asserted in the cycle after edge k + ROWS + 2*N, where N is the number of rows removed.
// Backpressure: none; a start that arrives while busy is ignored, and results hold until the next completion.
module line_clear_engine #(
  parameter int ROWS    = 22,
  parameter int COLS    = 10,
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  line_clear_engine_if.slave bus
);
  localparam int RW = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t                          state_q, state_d;
  logic [ROWS-1:0][COLS-1:0][2:0]  work_q;
  logic [ROWS-1:0][COLS-1:0][2:0]  grid_out_q;
  logic [RW-1:0]                   r_q;
  logic [4:0]                      n_q;
  logic [4:0]                      lines_q;
  logic [SCORE_W-1:0]              score_q;

  logic                            row_full;
  logic [SCORE_W-1:0]              pts;
  logic [SCORE_W:0]                score_sum;
  logic [SCORE_W-1:0]              score_sat;

  // The row under the pointer is full when every cell holds a non-zero colour
  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (work_q[r_q][c] == 3'd0) row_full = 1'b0;
    end
  end

  // Points for the rows removed so far, added to the score with saturation at all-ones
  always_comb begin
    case (n_q)
      5'd0:    pts = '0;
      5'd1:    pts = SCORE_W'(40);
      5'd2:    pts = SCORE_W'(100);
      5'd3:    pts = SCORE_W'(300);
      default: pts = SCORE_W'(1200);
    endcase
    score_sum = {1'b0, score_q} + {1'b0, pts};
    score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: a full row is shifted out and the same row index is then re-tested
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SCAN;
      SCAN: begin
        if (row_full)          state_d = SHIFT;
        else if (r_q == '0)    state_d = DONE;
        else                   state_d = SCAN;
      end
      SHIFT:   state_d = SCAN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working grid, pointers, and result registers; results only update on the edge that enters DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q     <= '0;
      grid_out_q <= '0;
      r_q        <= RW'(ROWS-1);
      n_q        <= '0;
      lines_q    <= '0;
      score_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            work_q <= bus.grid_in;
            r_q    <= RW'(ROWS-1);
            n_q    <= '0;
          end
        end
        SCAN: begin
          if (!row_full) begin
            if (r_q != '0) begin
              r_q <= r_q - 1'b1;
            end else begin
              grid_out_q <= work_q;
              lines_q    <= n_q;
              score_q    <= score_sat;
            end
          end
        end
        SHIFT: begin
          for (int i = 1; i < ROWS; i++) begin
            if (RW'(i) <= r_q) work_q[i] <= work_q[i-1];
          end
          work_q[0] <= '0;
          n_q       <= n_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.grid_out      = grid_out_q;
  assign bus.lines_cleared = lines_q;
  assign bus.score         = score_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == DONE);
endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: directed scenarios plus randomized grids compared against a compaction model.
module tb_line_clear_engine;
  localparam int ROWS    = 22;
  localparam int COLS    = 10;
  localparam int SCORE_W = 16;
  localparam int SAT     = 65535;

  typedef logic [ROWS-1:0][COLS-1:0][2:0] grid_t;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b0;
  int    checks   = 0;
  int    failures = 0;

  grid_t exp_grid;
  int    exp_lines;
  int    exp_score;

  line_clear_engine_if #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SCORE_W)) ifc ();

  line_clear_engine #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SCORE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_grid(input string tag, input grid_t obs, input grid_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_full(input grid_t g, input int r);
    for (int c = 0; c < COLS; c++) if (g[r][c] == 3'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int pts(input int n);
    case (n)
      0:       return 0;
      1:       return 40;
      2:       return 100;
      3:       return 300;
      default: return 1200;
    endcase
  endfunction

  // Reference: keep every non-full row in bottom-to-top order, stack them at the bottom, pad with empty rows
  function automatic grid_t model(input grid_t g, output int n);
    grid_t o;
    int    dst;
    o   = '0;
    dst = ROWS - 1;
    n   = 0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (is_full(g, i)) n++;
      else begin
        o[dst] = g[i];
        dst--;
      end
    end
    return o;
  endfunction

  function automatic grid_t rand_grid(input int full_pct);
    grid_t g;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (int'($urandom_range(99)) < full_pct) g[r][c] = 3'($urandom_range(7, 1));
        else                                      g[r][c] = 3'($urandom_range(7, 0));
      end
      if (int'($urandom_range(99)) >= full_pct && $urandom_range(1) == 1)
        g[r][$urandom_range(COLS-1)] = 3'd0;
    end
    return g;
  endfunction

  // One complete operation: start, scramble grid_in while busy, then check timing and results against the model
  task automatic run_op(input grid_t g, input bit extra_start, input string tag);
    grid_t mg;
    int    n;
    int    lat    = -1;
    int    pulses = 0;
    logic  busy_at_done = 1'b0;
    mg = model(g, n);
    @(negedge clk);
    ifc.grid_in = g;
    ifc.start   = 1'b1;
    @(negedge clk);
    ifc.start   = 1'b0;
    for (int c = 1; c <= 3 * ROWS + 10; c++) begin
      @(negedge clk);
      if (ifc.done) begin
        pulses++;
        if (lat < 0) begin
          lat          = c;
          busy_at_done = ifc.busy;
        end
      end
      if (c == 3) begin
        chk({tag, ".busy_mid"}, 32'(ifc.busy), 32'd1);
        chk_grid({tag, ".grid_hold"}, ifc.grid_out, exp_grid);
        chk({tag, ".lines_hold"}, 32'(ifc.lines_cleared), 32'(exp_lines));
      end
      ifc.grid_in = rand_grid(30);
      ifc.start   = extra_start && (c == 5);
    end
    ifc.start = 1'b0;
    exp_grid  = mg;
    exp_lines = n;
    exp_score = (exp_score + pts(n) > SAT) ? SAT : exp_score + pts(n);
    chk({tag, ".latency"}, 32'(lat), 32'(ROWS + 2 * n));
    chk({tag, ".done_pulses"}, 32'(pulses), 32'd1);
    chk({tag, ".busy_at_done"}, 32'(busy_at_done), 32'd1);
    chk({tag, ".lines"}, 32'(ifc.lines_cleared), 32'(exp_lines));
    chk({tag, ".score"}, 32'(ifc.score), 32'(exp_score));
    chk_grid({tag, ".grid"}, ifc.grid_out, exp_grid);
    chk({tag, ".busy_end"}, 32'(ifc.busy), 32'd0);
  endtask

  initial begin
    grid_t g;
    int    cancelled_pulses;

    ifc.start   = 1'b0;
    ifc.grid_in = '0;
    rst_n       = 1'b0;
    exp_grid    = '0;
    exp_lines   = 0;
    exp_score   = 0;
    repeat (3) @(negedge clk);
    chk("reset.busy",  32'(ifc.busy), 32'd0);
    chk("reset.done",  32'(ifc.done), 32'd0);
    chk("reset.lines", 32'(ifc.lines_cleared), 32'd0);
    chk("reset.score", 32'(ifc.score), 32'd0);
    chk_grid("reset.grid", ifc.grid_out, '0);
    rst_n = 1'b1;

    // Empty grid
    run_op('0, 1'b0, "empty");

    // Single full bottom row with one cell resting on it
    g = '0;
    for (int c = 0; c < COLS; c++) g[21][c] = 3'b100;
    g[20][4] = 3'b010;
    run_op(g, 1'b0, "single");
    chk("single.cell_21_4", 32'(ifc.grid_out[21][4]), 32'b010);
    chk("single.score_abs", 32'(ifc.score), 32'd40);

    // Two non-contiguous full rows
    g = '0;
    for (int c = 0; c < COLS; c++) begin
      g[21][c] = 3'($urandom_range(7, 1));
      g[19][c] = 3'($urandom_range(7, 1));
    end
    g[20][0] = 3'b001;
    run_op(g, 1'b0, "noncontig");
    chk("noncontig.cell_21_0", 32'(ifc.grid_out[21][0]), 32'b001);

    // Tetris with a second start while busy
    g = '0;
    for (int r = 18; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) g[r][c] = 3'($urandom_range(7, 1));
    g[17][3] = 3'b110;
    run_op(g, 1'b1, "tetris");
    chk("tetris.cell_21_3", 32'(ifc.grid_out[21][3]), 32'b110);

    // Full grid including row 0
    g = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) g[r][c] = 3'($urandom_range(7, 1));
    run_op(g, 1'b0, "all_full");

    // Randomized grids
    for (int t = 0; t < 12; t++) run_op(rand_grid(35), 1'b0, $sformatf("rand%0d", t));

    // Reset while the engine is shifting a full bottom row
    g = rand_grid(20);
    for (int c = 0; c < COLS; c++) g[21][c] = 3'b011;
    @(negedge clk);
    ifc.grid_in = g;
    ifc.start   = 1'b1;
    @(negedge clk);
    ifc.start   = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.busy",  32'(ifc.busy), 32'd0);
    chk("midrst.done",  32'(ifc.done), 32'd0);
    chk("midrst.lines", 32'(ifc.lines_cleared), 32'd0);
    chk("midrst.score", 32'(ifc.score), 32'd0);
    chk_grid("midrst.grid", ifc.grid_out, '0);
    exp_grid  = '0;
    exp_lines = 0;
    exp_score = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cancelled_pulses = 0;
    for (int c = 0; c < 2 * ROWS + 10; c++) begin
      @(negedge clk);
      if (ifc.done) cancelled_pulses++;
    end
    chk("midrst.no_done", 32'(cancelled_pulses), 32'd0);
    chk("midrst.score_kept", 32'(ifc.score), 32'd0);
    run_op(g, 1'b0, "post_reset");

    // Drive the score toward saturation with repeated four-row clears
    while (exp_score < 64400) begin
      g = rand_grid(0);
      for (int r = 18; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) g[r][c] = 3'($urandom_range(7, 1));
      run_op(g, 1'b0, "preload");
    end
    g = '0;
    for (int r = 18; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) g[r][c] = 3'b101;
    run_op(g, 1'b0, "saturate");
    chk("saturate.score_abs", 32'(ifc.score), 32'(SAT));
    run_op(g, 1'b0, "saturate_hold");
    chk("saturate_hold.score_abs", 32'(ifc.score), 32'(SAT));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
